reindeer_trap_sequencer: RTL

//  Sequences machine-mode trap entry and MRET exit around the CSR file. Arbitrates synchronous exceptions vs external/timer

---
 rtl/reindeer_trap_sequencer_pkg.sv | 17 +
 rtl/reindeer_trap_sequencer_target.sv | 32 +++
 rtl/reindeer_trap_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/reindeer_trap_sequencer_pkg.sv
// Shared cause codes, mtvec mode encoding and trap sequencer state encoding.
package reindeer_trap_sequencer_pkg;

    localparam int CAUSE_M_TIMER = 7;
    localparam int CAUSE_M_EXT   = 11;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_MRET     = 3'd4
    } trap_state_e;

endpackage

// File: rtl/reindeer_trap_sequencer_target.sv
// Fetch redirect target: mepc on MRET, otherwise mtvec base plus an optional vector offset.
module reindeer_trap_sequencer_target
    import reindeer_trap_sequencer_pkg::*;
#(
    parameter int PC_BITWIDTH         = 32,
    parameter int XLEN                = 32,
    parameter int EXCEPTION_CODE_BITS = 4
) (
    input  logic [XLEN-1:0]                mtvec,
    input  logic [XLEN-1:0]                mepc,
    input  logic                           use_mepc,
    input  logic                           is_interrupt,
    input  logic [EXCEPTION_CODE_BITS-1:0] code,
    output logic [PC_BITWIDTH-1:0]         target
);

    logic [PC_BITWIDTH-1:0] base;
    logic [PC_BITWIDTH-1:0] offset;

    always_comb begin
        base   = mtvec[PC_BITWIDTH-1:0] & ~PC_BITWIDTH'(3);
        offset = PC_BITWIDTH'({code, 2'b00});
        target = base;
        if (use_mepc) begin
            target = mepc[PC_BITWIDTH-1:0];
        end else if (is_interrupt && (mtvec[1:0] == MTVEC_MODE_VECTORED)) begin
            // Vector offset wraps silently at the PC width.
            target = base + offset;
        end
    end

endmodule

// File: rtl/reindeer_trap_sequencer.sv
// Machine-mode trap entry / MRET exit sequencer between pipeline, CSR file and fetch.
//   state    | meaning
//   IDLE     | running normally; fetch not stalled
//   DRAIN    | interrupt pending, fetch stalled until pipeline empties
//   COMMIT   | capture strobe to CSR with held cause/PC/addr
//   MRET     | MRET strobe to CSR, target taken from mepc
//   REDIRECT | one-cycle fetch redirect to registered target
module reindeer_trap_sequencer
    import reindeer_trap_sequencer_pkg::*;
#(
    parameter int PC_BITWIDTH         = 32,
    parameter int XLEN                = 32,
    parameter int EXCEPTION_CODE_BITS = 4
) (
    input  logic                           clk,
    input  logic                           sync_reset,
    input  logic                           exc_req,
    input  logic [EXCEPTION_CODE_BITS-1:0] exc_code,
    input  logic [PC_BITWIDTH-1:0]         exc_pc,
    input  logic [PC_BITWIDTH-1:0]         exc_addr,
    input  logic                           mret_req,
    input  logic [PC_BITWIDTH-1:0]         next_pc,
    input  logic                           pipeline_idle,
    input  logic                           mie,
    input  logic                           mtie,
    input  logic                           meie,
    input  logic                           mtip,
    input  logic                           meip,
    input  logic [XLEN-1:0]                mtvec,
    input  logic [XLEN-1:0]                mepc,
    output logic                           stall_fetch,
    output logic                           activate_exception,
    output logic                           is_interrupt,
    output logic [EXCEPTION_CODE_BITS-1:0] exception_code,
    output logic [PC_BITWIDTH-1:0]         exception_PC,
    output logic [PC_BITWIDTH-1:0]         exception_addr,
    output logic                           csr_mret_active,
    output logic                           pc_redirect,
    output logic [PC_BITWIDTH-1:0]         pc_redirect_addr,
    output logic                           in_handler
);

    trap_state_e                    state_q, state_d;
    logic                           in_handler_q, in_handler_d;
    logic                           is_int_q, is_int_d;
    logic [EXCEPTION_CODE_BITS-1:0] code_q, code_d;
    logic [PC_BITWIDTH-1:0]         pc_q, pc_d;
    logic [PC_BITWIDTH-1:0]         addr_q, addr_d;
    logic [PC_BITWIDTH-1:0]         redirect_addr_q, redirect_addr_d;

    logic                           ext_pend;
    logic                           tmr_pend;
    logic                           int_pend;
    logic [PC_BITWIDTH-1:0]         target;

    assign ext_pend = meie & meip;
    assign tmr_pend = mtie & mtip;
    assign int_pend = mie & ~in_handler_q & (ext_pend | tmr_pend);

    reindeer_trap_sequencer_target #(
        .PC_BITWIDTH         (PC_BITWIDTH),
        .XLEN                (XLEN),
        .EXCEPTION_CODE_BITS (EXCEPTION_CODE_BITS)
    ) u_target (
        .mtvec        (mtvec),
        .mepc         (mepc),
        .use_mepc     (state_q == ST_MRET),
        .is_interrupt (is_int_q),
        .code         (code_q),
        .target       (target)
    );

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q         <= ST_IDLE;
            in_handler_q    <= 1'b0;
            is_int_q        <= 1'b0;
            code_q          <= '0;
            pc_q            <= '0;
            addr_q          <= '0;
            redirect_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            in_handler_q    <= in_handler_d;
            is_int_q        <= is_int_d;
            code_q          <= code_d;
            pc_q            <= pc_d;
            addr_q          <= addr_d;
            redirect_addr_q <= redirect_addr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        in_handler_d    = in_handler_q;
        is_int_d        = is_int_q;
        code_d          = code_q;
        pc_d            = pc_q;
        addr_d          = addr_q;
        redirect_addr_d = redirect_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_req) begin
                    is_int_d = 1'b0;
                    code_d   = exc_code;
                    pc_d     = exc_pc;
                    addr_d   = exc_addr;
                    state_d  = ST_COMMIT;
                end else if (mret_req) begin
                    state_d = ST_MRET;
                end else if (int_pend) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (exc_req) begin
                    is_int_d = 1'b0;
                    code_d   = exc_code;
                    pc_d     = exc_pc;
                    addr_d   = exc_addr;
                    state_d  = ST_COMMIT;
                end else if (!int_pend) begin
                    state_d = ST_IDLE;
                end else if (pipeline_idle) begin
                    // Cause is re-evaluated here; external may have arrived during the drain.
                    is_int_d = 1'b1;
                    code_d   = ext_pend ? EXCEPTION_CODE_BITS'(CAUSE_M_EXT)
                                        : EXCEPTION_CODE_BITS'(CAUSE_M_TIMER);
                    pc_d     = next_pc;
                    addr_d   = '0;
                    state_d  = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                in_handler_d    = 1'b1;
                redirect_addr_d = target;
                state_d         = ST_REDIRECT;
            end
            ST_MRET: begin
                in_handler_d    = 1'b0;
                redirect_addr_d = target;
                state_d         = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        stall_fetch        = (state_q != ST_IDLE);
        activate_exception = (state_q == ST_COMMIT);
        csr_mret_active    = (state_q == ST_MRET);
        pc_redirect        = (state_q == ST_REDIRECT);
        pc_redirect_addr   = (state_q == ST_REDIRECT) ? redirect_addr_q : '0;
        is_interrupt       = is_int_q;
        exception_code     = code_q;
        exception_PC       = pc_q;
        exception_addr     = addr_q;
        in_handler         = in_handler_q;
    end

endmodule
